// File: rtl/psola_pkg.sv
// Shared constants, state encoding and fixed-point helpers for the PSOLA
// output path (the PSOLA accumulator block uses the same constants).
package psola_pkg;

  localparam int MAX_EXTENDED  = 2200;
  localparam int FRACTION_BITS = 14;
  localparam int ADDR_W        = $clog2(MAX_EXTENDED);
  localparam int LEN_W         = 12;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    WAIT,
    CONVERT
  } state_t;

  // Drop the fractional bits (arithmetic shift) and clamp to a signed 16-bit sample.
  function automatic logic signed [15:0] sat16(input logic signed [31:0] acc);
    logic signed [31:0] shifted;
    shifted = acc >>> FRACTION_BITS;
    if (shifted > 32'sd32767) return 16'sh7fff;
    if (shifted < -32'sd32768) return 16'sh8000;
    return shifted[15:0];
  endfunction

endpackage

// File: rtl/psola_playback_if.sv
// Signal bundle between the playback block, the PSOLA buffer's second port
// and the audio output path.
interface psola_playback_if;
  import psola_pkg::*;

  // window_len_valid_in has no ready: a window is accepted only while
  // busy_out is low; a pulse that arrives while busy is dropped and flagged
  // one cycle later on overrun_out. sample_valid_out is a single-cycle
  // strobe with no backpressure from the audio path.
  logic [LEN_W-1:0]  window_len_in;
  logic              window_len_valid_in;
  logic [ADDR_W-1:0] read_addr;
  logic [31:0]       read_val;
  logic [ADDR_W-1:0] clear_addr;
  logic              clear_we;
  logic [15:0]       sample_out;
  logic              sample_valid_out;
  logic              busy_out;
  logic              done_out;
  logic              underrun_out;
  logic              overrun_out;
  state_t            state_dbg;

  modport master (
    input  window_len_in, window_len_valid_in, read_val,
    output read_addr, clear_addr, clear_we, sample_out, sample_valid_out,
           busy_out, done_out, underrun_out, overrun_out, state_dbg
  );

  modport slave (
    output window_len_in, window_len_valid_in, read_val,
    input  read_addr, clear_addr, clear_we, sample_out, sample_valid_out,
           busy_out, done_out, underrun_out, overrun_out, state_dbg
  );

endinterface

// File: rtl/psola_playback_sample_ticker.sv
// Free-running audio-rate tick generator: one-cycle pulse every PERIOD clocks.
module sample_ticker #(
  parameter int PERIOD = 2268
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [CW-1:0] count;

  assign tick = (count == CW'(PERIOD - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/psola_playback.sv
// Drains the PSOLA overlap-add buffer one sample per audio tick, saturating
// each accumulation to 16 bits and zeroing the location behind it.
module psola_playback
  import psola_pkg::*;
#(
  parameter int SAMPLE_PERIOD = 2268,
  parameter int BRAM_LATENCY  = 2
) (
  input logic              clk_in,
  input logic              rst_in,
  psola_playback_if.master bus
);

  localparam int LAT_W = $clog2(BRAM_LATENCY + 2);

  logic tick;

  sample_ticker #(.PERIOD(SAMPLE_PERIOD)) u_ticker (
    .clk  (clk_in),
    .rst  (rst_in),
    .tick (tick)
  );

  state_t            state, state_next;
  logic [ADDR_W-1:0] idx, idx_next;
  logic [ADDR_W-1:0] last_idx, last_idx_next;
  logic [LAT_W-1:0]  wait_cnt, wait_cnt_next;
  logic [ADDR_W-1:0] read_addr, read_addr_next;
  logic [ADDR_W-1:0] clear_addr, clear_addr_next;
  logic              clear_we, clear_we_next;
  logic [15:0]       sample, sample_next;
  logic              sample_valid, sample_valid_next;
  logic              done, done_next;
  logic              underrun, underrun_next;
  logic              overrun, overrun_next;
  logic [1:0]        idle_pipe, idle_pipe_next;
  logic              idle_tick;
  logic              at_last;
  logic [LEN_W-1:0]  len_clamped;

  assign len_clamped = (bus.window_len_in > LEN_W'(MAX_EXTENDED)) ?
                       LEN_W'(MAX_EXTENDED) : bus.window_len_in;
  assign at_last     = (idx == last_idx);

  // A tick that no window will consume: either nothing is loaded, or the
  // final CONVERT of a window coincides with a tick (only possible at the
  // minimum sample period). It still produces a zero sample to keep cadence.
  assign idle_tick = tick && ((state == IDLE) || (state == CONVERT && at_last));

  always_comb begin
    state_next        = state;
    idx_next          = idx;
    last_idx_next     = last_idx;
    wait_cnt_next     = wait_cnt;
    read_addr_next    = read_addr;
    clear_addr_next   = clear_addr;
    clear_we_next     = 1'b0;
    sample_next       = sample;
    sample_valid_next = 1'b0;
    done_next         = 1'b0;
    underrun_next     = 1'b0;
    overrun_next      = 1'b0;
    idle_pipe_next    = {idle_pipe[0], idle_tick};

    if (idle_pipe[1]) begin
      sample_next       = '0;
      sample_valid_next = 1'b1;
      underrun_next     = 1'b1;
    end

    if (bus.window_len_valid_in && state != IDLE) begin
      overrun_next = 1'b1;
    end

    case (state)
      IDLE: begin
        if (bus.window_len_valid_in) begin
          if (len_clamped == '0) begin
            done_next = 1'b1;
          end else begin
            idx_next      = '0;
            last_idx_next = ADDR_W'(len_clamped - LEN_W'(1));
            state_next    = ARMED;
          end
        end
      end
      ARMED: begin
        if (tick) begin
          read_addr_next = idx;
          wait_cnt_next  = '0;
          state_next     = WAIT;
        end
      end
      WAIT: begin
        // Outputs are registered here so they are visible during CONVERT.
        if (wait_cnt == LAT_W'(BRAM_LATENCY)) begin
          sample_next       = sat16($signed(bus.read_val));
          sample_valid_next = 1'b1;
          clear_addr_next   = idx;
          clear_we_next     = 1'b1;
          done_next         = at_last;
          state_next        = CONVERT;
        end else begin
          wait_cnt_next = wait_cnt + LAT_W'(1);
        end
      end
      CONVERT: begin
        if (at_last) begin
          state_next = IDLE;
        end else begin
          idx_next = idx + ADDR_W'(1);
          if (tick) begin
            read_addr_next = idx + ADDR_W'(1);
            wait_cnt_next  = '0;
            state_next     = WAIT;
          end else begin
            state_next = ARMED;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state        <= IDLE;
      idx          <= '0;
      last_idx     <= '0;
      wait_cnt     <= '0;
      read_addr    <= '0;
      clear_addr   <= '0;
      clear_we     <= 1'b0;
      sample       <= '0;
      sample_valid <= 1'b0;
      done         <= 1'b0;
      underrun     <= 1'b0;
      overrun      <= 1'b0;
      idle_pipe    <= '0;
    end else begin
      state        <= state_next;
      idx          <= idx_next;
      last_idx     <= last_idx_next;
      wait_cnt     <= wait_cnt_next;
      read_addr    <= read_addr_next;
      clear_addr   <= clear_addr_next;
      clear_we     <= clear_we_next;
      sample       <= sample_next;
      sample_valid <= sample_valid_next;
      done         <= done_next;
      underrun     <= underrun_next;
      overrun      <= overrun_next;
      idle_pipe    <= idle_pipe_next;
    end
  end

  assign bus.read_addr        = read_addr;
  assign bus.clear_addr       = clear_addr;
  assign bus.clear_we         = clear_we;
  assign bus.sample_out       = sample;
  assign bus.sample_valid_out = sample_valid;
  assign bus.busy_out         = (state != IDLE);
  assign bus.done_out         = done;
  assign bus.underrun_out     = underrun;
  assign bus.overrun_out      = overrun;
  assign bus.state_dbg        = state;

endmodule

// File: tb/tb_psola_playback.sv
// Directed bench for psola_playback with a behavioural two-cycle BRAM model.
module tb_psola_playback;
  import psola_pkg::*;

  localparam int SP = 8;
  localparam int BL = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  psola_playback_if bus ();

  psola_playback #(.SAMPLE_PERIOD(SP), .BRAM_LATENCY(BL)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  // ---------------- buffer model ----------------
  logic [31:0]       mem [MAX_EXTENDED];
  logic [31:0]       d1, d2;
  logic              tb_we, tb_fill;
  logic [ADDR_W-1:0] tb_waddr;
  logic [31:0]       tb_wdata;

  always @(posedge clk) begin
    if (tb_fill) begin
      for (int i = 0; i < MAX_EXTENDED; i++) mem[i] <= 32'(i) << FRACTION_BITS;
    end else if (tb_we) begin
      mem[tb_waddr] <= tb_wdata;
    end
    if (bus.clear_we) mem[bus.clear_addr] <= '0;
    d1 <= mem[bus.read_addr];
    d2 <= d1;
  end
  assign bus.read_val = d2;

  // ---------------- monitor ----------------
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0]       obs_s_q[$];
  logic              obs_u_q[$];
  logic              obs_d_q[$];
  int                obs_c_q[$];
  logic [ADDR_W-1:0] clr_q[$];
  int                done_cnt = 0;
  int                over_cnt = 0;

  always @(negedge clk) begin
    if (bus.sample_valid_out) begin
      obs_s_q.push_back(bus.sample_out);
      obs_u_q.push_back(bus.underrun_out);
      obs_d_q.push_back(bus.done_out);
      obs_c_q.push_back(cyc);
    end
    if (bus.clear_we) clr_q.push_back(bus.clear_addr);
    if (bus.done_out) done_cnt++;
    if (bus.overrun_out) over_cnt++;
  end

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];
  int checks = 0;
  int failures = 0;
  int rd = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mem_write(input logic [ADDR_W-1:0] a, input logic [31:0] v);
    tb_waddr = a;
    tb_wdata = v;
    tb_we    = 1'b1;
    step();
    tb_we    = 1'b0;
  endtask

  task automatic next_sample(output logic [15:0] s, output logic u, output logic d, output int c);
    int n = 0;
    while (obs_s_q.size() <= rd && n < 3 * SP) begin
      step();
      n++;
    end
    check("sample_arrives", 32'(obs_s_q.size() > rd), 32'd1);
    s = 16'hdead;
    u = 1'bx;
    d = 1'bx;
    c = -1;
    if (obs_s_q.size() > rd) begin
      s = obs_s_q[rd];
      u = obs_u_q[rd];
      d = obs_d_q[rd];
      c = obs_c_q[rd];
      rd++;
    end
  endtask

  // Align to a fresh underrun pulse, then hand over a window one cycle later.
  task automatic start_window(input logic [LEN_W-1:0] len, output int cu);
    int   n = 0;
    logic found = 1'b0;
    cu = 0;
    rd = obs_s_q.size();
    while (!found && n < 4 * SP) begin
      step();
      n++;
      while (obs_s_q.size() > rd) begin
        if (obs_u_q[rd]) begin
          found = 1'b1;
          cu    = obs_c_q[rd];
        end
        rd++;
      end
    end
    check("sync_underrun", 32'(found), 32'd1);
    bus.window_len_in       = len;
    bus.window_len_valid_in = 1'b1;
    step();
    bus.window_len_valid_in = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [15:0] s;
    logic        u, d;
    int          c, cu, c_prev, base_clr, base_done, base_over, bad;

    rst                     = 1'b1;
    tb_we                   = 1'b0;
    tb_fill                 = 1'b0;
    tb_waddr                = '0;
    tb_wdata                = '0;
    bus.window_len_in       = '0;
    bus.window_len_valid_in = 1'b0;
    repeat (3) step();

    check("rst_sample_valid", 32'(bus.sample_valid_out), 32'd0);
    check("rst_sample_out",   32'(bus.sample_out),       32'd0);
    check("rst_busy",         32'(bus.busy_out),         32'd0);
    check("rst_done",         32'(bus.done_out),         32'd0);
    check("rst_clear_we",     32'(bus.clear_we),         32'd0);
    check("rst_read_addr",    32'(bus.read_addr),        32'd0);
    check("rst_state",        32'(bus.state_dbg),        32'(IDLE));
    rst = 1'b0;

    // Basic window: 0x14000 -> 5, 0xFFFFC000 -> -1, 0x2000 -> 0.
    mem_write(0, 32'h0001_4000);
    mem_write(1, 32'hffff_c000);
    mem_write(2, 32'h0000_2000);
    base_clr  = clr_q.size();
    base_done = done_cnt;
    exp_q.push_back(16'd5);
    exp_q.push_back(16'hffff);
    exp_q.push_back(16'd0);
    start_window(12'd3, cu);
    for (int k = 0; k < 3; k++) begin
      next_sample(s, u, d, c);
      check("basic_sample",   32'(s), 32'(exp_q.pop_front()));
      check("basic_underrun", 32'(u), 32'd0);
      check("basic_done",     32'(d), 32'(k == 2));
      check("basic_timing",   32'(c), 32'(cu + 9 + 8 * k));
    end
    check("basic_busy_after",  32'(bus.busy_out), 32'd0);
    check("basic_done_count",  32'(done_cnt - base_done), 32'd1);
    check("basic_clear_count", 32'(clr_q.size() - base_clr), 32'd3);
    for (int k = 0; k < 3; k++) begin
      check("basic_clear_addr", 32'(clr_q[base_clr + k]), 32'(k));
      check("basic_mem_zeroed", mem[k], 32'd0);
    end

    // Saturation at both rails.
    mem_write(0, 32'h7fff_ffff);
    mem_write(1, 32'h8000_0000);
    exp_q.push_back(16'h7fff);
    exp_q.push_back(16'h8000);
    start_window(12'd2, cu);
    for (int k = 0; k < 2; k++) begin
      next_sample(s, u, d, c);
      check("sat_sample", 32'(s), 32'(exp_q.pop_front()));
      check("sat_done",   32'(d), 32'(k == 1));
    end

    // Zero-length window completes immediately.
    base_done               = done_cnt;
    bus.window_len_in       = 12'd0;
    bus.window_len_valid_in = 1'b1;
    step();
    bus.window_len_valid_in = 1'b0;
    check("len0_done", 32'(bus.done_out), 32'd1);
    check("len0_busy", 32'(bus.busy_out), 32'd0);

    // Idle ticks: zero samples flagged as underrun, no clears.
    base_clr = clr_q.size();
    rd       = obs_s_q.size();
    c_prev   = -1;
    for (int k = 0; k < 3; k++) begin
      next_sample(s, u, d, c);
      check("idle_sample",   32'(s), 32'd0);
      check("idle_underrun", 32'(u), 32'd1);
      if (k > 0) check("idle_spacing", 32'(c - c_prev), 32'(SP));
      c_prev = c;
    end
    check("idle_no_clear", 32'(clr_q.size() - base_clr), 32'd0);

    // Overrun: len=5 offered while a len=4 window plays.
    for (int k = 0; k < 4; k++) mem_write(ADDR_W'(k), 32'(k + 1) << FRACTION_BITS);
    base_done = done_cnt;
    base_over = over_cnt;
    start_window(12'd4, cu);
    step();
    step();
    bus.window_len_in       = 12'd5;
    bus.window_len_valid_in = 1'b1;
    step();
    bus.window_len_valid_in = 1'b0;
    for (int k = 0; k < 4; k++) begin
      next_sample(s, u, d, c);
      check("ovr_sample", 32'(s), 32'(k + 1));
      check("ovr_done",   32'(d), 32'(k == 3));
    end
    next_sample(s, u, d, c);
    check("ovr_fifth_is_underrun", 32'(u), 32'd1);
    check("ovr_count",  32'(over_cnt - base_over), 32'd1);
    check("ovr_done_count", 32'(done_cnt - base_done), 32'd1);

    // Length clamp: 4000 -> 2200 over a ramp where sample k == k.
    tb_fill = 1'b1;
    step();
    tb_fill   = 1'b0;
    base_clr  = clr_q.size();
    base_done = done_cnt;
    bad       = 0;
    start_window(12'd4000, cu);
    for (int k = 0; k < MAX_EXTENDED; k++) begin
      next_sample(s, u, d, c);
      if (s !== 16'(k) || u !== 1'b0 || d !== (k == MAX_EXTENDED - 1)) bad++;
    end
    check("clamp_stream_errors", 32'(bad), 32'd0);
    check("clamp_last_read",     32'(bus.read_addr), 32'd2199);
    check("clamp_clear_count",   32'(clr_q.size() - base_clr), 32'(MAX_EXTENDED));
    check("clamp_last_clear",    32'(clr_q[clr_q.size() - 1]), 32'd2199);
    check("clamp_done_count",    32'(done_cnt - base_done), 32'd1);

    // Reset during WAIT of the second sample.
    mem_write(0, 32'd3 << FRACTION_BITS);
    mem_write(1, 32'd7 << FRACTION_BITS);
    start_window(12'd2, cu);
    next_sample(s, u, d, c);
    check("rstmid_first_sample", 32'(s), 32'd3);
    c = 0;
    while (cyc < cu + 15 && c < 40) begin
      step();
      c++;
    end
    check("rstmid_in_wait", 32'(bus.state_dbg), 32'(WAIT));
    rst = 1'b1;
    step();
    check("rstmid_valid", 32'(bus.sample_valid_out), 32'd0);
    check("rstmid_sample", 32'(bus.sample_out), 32'd0);
    check("rstmid_busy",  32'(bus.busy_out), 32'd0);
    check("rstmid_done",  32'(bus.done_out), 32'd0);
    check("rstmid_clear", 32'(bus.clear_we), 32'd0);
    check("rstmid_raddr", 32'(bus.read_addr), 32'd0);
    rst = 1'b0;
    next_sample(s, u, d, c);
    check("rstmid_no_second_sample", 32'(u), 32'd1);
    check("rstmid_not_cleared", mem[1], 32'd7 << FRACTION_BITS);

    mem_write(0, 32'd9 << FRACTION_BITS);
    start_window(12'd1, cu);
    next_sample(s, u, d, c);
    check("post_rst_sample", 32'(s), 32'd9);
    check("post_rst_done",   32'(d), 32'd1);
    check("post_rst_timing", 32'(c), 32'(cu + 9));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
